// File: rtl/spu_rot_shift_pipe_if.sv
// ============================================================================
// Module   : spu_rot_shift_pipe_if
// Brief    : Issue-side and result-side handshake bundle for spu_rot_shift_pipe.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface spu_rot_shift_pipe_if #(
  parameter int TAG_W = 7
);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic             esz;
  logic [0:127]     ra;
  logic [0:127]     rb;
  logic [0:TAG_W-1] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [0:127]     out_data;
  logic [0:TAG_W-1] out_tag;

  modport master (
    output flush, in_valid, op, esz, ra, rb, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag
  );

  modport slave (
    input  flush, in_valid, op, esz, ra, rb, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag
  );
endinterface

`default_nettype wire

// File: rtl/spu_rot_shift_pipe.sv
// ============================================================================
// Module   : spu_rot_shift_pipe
// Brief    : Pipelined per-lane rotate/shift unit; SPU_ROT_QUAD_EN adds byte ops.
// Revision : 1.0
// ============================================================================
`default_nettype none

module spu_rot_shift_pipe #(
  parameter int PIPE_STAGES = 2,
  parameter int TAG_W       = 7
) (
  input  logic                clk,
  input  logic                rst,
  spu_rot_shift_pipe_if.slave bus
);

  localparam logic [2:0] c_OP_ROT    = 3'b000;
  localparam logic [2:0] c_OP_SHL    = 3'b001;
  localparam logic [2:0] c_OP_ROTM   = 3'b010;
  localparam logic [2:0] c_OP_ROTMA  = 3'b011;
  localparam logic [2:0] c_OP_ROTQBY = 3'b100;
  localparam logic [2:0] c_OP_SHLQBY = 3'b101;

  // Halfword lanes arrive zero-extended in a[15:0]; cnt is the lane's low six bits.
  function automatic logic [31:0] f_lane(input logic [2:0] op, input logic [31:0] a,
                                         input logic [5:0] cnt, input logic is_word);
    logic [5:0]         w;
    logic [5:0]         c;
    logic [5:0]         neg;
    logic [31:0]        mask;
    logic [31:0]        sx;
    logic signed [31:0] ss;
    logic [63:0]        dbl;
    logic [31:0]        r;
    w    = is_word ? 6'd32 : 6'd16;
    mask = is_word ? 32'hFFFF_FFFF : 32'h0000_FFFF;
    neg  = 6'd0 - cnt;
    sx   = is_word ? a : {{16{a[15]}}, a[15:0]};
    r    = a;
    c    = 6'd0;
    dbl  = 64'd0;
    ss   = 32'sd0;
    case (op)
      c_OP_ROT: begin
        c = is_word ? {1'b0, cnt[4:0]} : {2'b00, cnt[3:0]};
        if (is_word) begin
          dbl = {a, a} << c;
          r   = dbl[63:32];
        end else begin
          dbl = {a[15:0], a[15:0], 32'h0} << c;
          r   = {16'h0, dbl[63:48]};
        end
      end
      c_OP_SHL: begin
        c = is_word ? cnt : {1'b0, cnt[4:0]};
        r = (c >= w) ? 32'h0 : ((a << c) & mask);
      end
      c_OP_ROTM: begin
        c = is_word ? neg : {1'b0, neg[4:0]};
        r = (c >= w) ? 32'h0 : (a >> c);
      end
      c_OP_ROTMA: begin
        c = is_word ? neg : {1'b0, neg[4:0]};
        // Shifting by W-1 already yields all sign bits, so larger counts clamp there.
        if (c >= w) c = w - 6'd1;
        ss = $signed(sx) >>> c;
        r  = $unsigned(ss) & mask;
      end
      default: r = a;
    endcase
    return r;
  endfunction

  logic [0:127] w_res_h;
  logic [0:127] w_res_w;
  logic [0:127] w_res;
  logic         w_adv;
  logic         w_unused;

  for (genvar i = 0; i < 8; i++) begin : g_hw
    assign w_res_h[16*i +: 16] =
      16'(f_lane(bus.op, {16'h0, bus.ra[16*i +: 16]}, bus.rb[16*i+10 +: 6], 1'b0));
  end

  for (genvar i = 0; i < 4; i++) begin : g_wd
    assign w_res_w[32*i +: 32] = f_lane(bus.op, bus.ra[32*i +: 32], bus.rb[32*i+26 +: 6], 1'b1);
  end

`ifdef SPU_ROT_QUAD_EN
  logic [127:0] w_q_src;
  logic [255:0] w_q_dbl;
  logic [127:0] w_q_rot;
  logic [127:0] w_q_shl;

  assign w_q_src = bus.ra;
  assign w_q_dbl = {w_q_src, w_q_src} << {bus.rb[124:127], 3'b000};
  assign w_q_rot = w_q_dbl[255:128];
  assign w_q_shl = bus.rb[123] ? 128'h0 : (w_q_src << {bus.rb[124:127], 3'b000});
`endif

  always_comb begin
    w_res = bus.ra;
    case (bus.op)
      c_OP_ROT, c_OP_SHL, c_OP_ROTM, c_OP_ROTMA: w_res = bus.esz ? w_res_w : w_res_h;
`ifdef SPU_ROT_QUAD_EN
      c_OP_ROTQBY: w_res = w_q_rot;
      c_OP_SHLQBY: w_res = w_q_shl;
`endif
      default: w_res = bus.ra;
    endcase
  end

  // Only the low count bits of each rb lane matter.
  assign w_unused = ^bus.rb;

  logic [PIPE_STAGES-1:0] r_vld;
  logic [0:127]           r_data [PIPE_STAGES];
  logic [0:TAG_W-1]       r_tag  [PIPE_STAGES];

  // Global enable: the whole pipe moves together, bubbles are not squeezed out.
  assign w_adv         = bus.out_ready | ~r_vld[PIPE_STAGES-1];
  assign bus.in_ready  = w_adv & ~rst;
  assign bus.out_valid = r_vld[PIPE_STAGES-1];
  assign bus.out_data  = r_data[PIPE_STAGES-1];
  assign bus.out_tag   = r_tag[PIPE_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld <= '0;
      for (int k = 0; k < PIPE_STAGES; k++) begin
        r_data[k] <= '0;
        r_tag[k]  <= '0;
      end
    end else if (w_adv) begin
      r_vld[0]  <= bus.in_valid & ~bus.flush;
      r_data[0] <= w_res;
      r_tag[0]  <= bus.in_tag;
      for (int k = 1; k < PIPE_STAGES; k++) begin
        r_vld[k]  <= r_vld[k-1] & ~bus.flush;
        r_data[k] <= r_data[k-1];
        r_tag[k]  <= r_tag[k-1];
      end
    end else if (bus.flush) begin
      r_vld <= '0;
    end
  end

endmodule

`default_nettype wire

// File: doc/spu_rot_shift_pipe.md
# spu_rot_shift_pipe

Pipelined, parametrised rotate/shift execution unit for the SPU odd/even fixed-point datapath. Performs element-wise rotate, shift-left, logical and arithmetic rotate-and-mask right on 128-bit quadwords at halfword or word granularity, with per-lane counts taken from `rb`. A valid/ready handshake with global stall and flush lets it sit behind the issue stage and in front of the result-forwarding network.

## Interface
Parameters:
- `PIPE_STAGES`, default 2: register stages between input and output, legal 1..3; latency equals this value.
- `TAG_W`, default 7: width of the opaque tag (target register number) carried with each operation.

Ports (all vectors big-endian `[0:N-1]`, bit 0 = MSB):
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `flush`  in  1  kill all in-flight operations.
- `in_valid`  in  1  operation presented.
- `in_ready`  out  1  unit accepts this cycle.
- `op`  in  3  000 ROT, 001 SHL, 010 ROTM, 011 ROTMA, 100 ROTQBY, 101 SHLQBY, 11x reserved.
- `esz`  in  1  0 = halfword (8 lanes x 16), 1 = word (4 lanes x 32); ignored by quadword ops.
- `ra`  in  128  source data.
- `rb`  in  128  per-lane counts.
- `in_tag`  in  `TAG_W`  tag.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts.
- `out_data`  out  128  result.
- `out_tag`  out  `TAG_W`  tag of result.

## Operation
- Lane width W = 16 or 32; count c read from the low bits of the same lane of `rb`.
- ROT: rotate lane left by c mod W (mask W-1).
- SHL: c = lane count & (2W-1); shift left, zero fill; c >= W gives 0.
- ROTM: c = (-lane count) & (2W-1); logical shift right, zero fill; c >= W gives 0.
- ROTMA: c as ROTM; arithmetic shift right, sign fill; c >= W gives all sign bits.
- ROTQBY / SHLQBY: whole-quadword byte ops, only with `SPU_ROT_QUAD_EN` (see Configuration).
- Reserved opcodes: result = `ra` unchanged, still valid and tagged.
- Computation completes in stage 0; remaining stages are pure registers. Each stage holds valid, data and tag.

## Timing
- Reset: `out_valid`=0, `out_data`=0, `out_tag`=0, all internal valid bits 0; `in_ready`=0 while `rst` is high.
- Advance condition `adv` = `out_ready` | !`out_valid`; `in_ready` = `adv` & !`rst`. This is a global enable with no bubble collapsing.
- Transfer on `in_valid` & `in_ready`; the result appears with `out_valid`=1 exactly `PIPE_STAGES` cycles later if never stalled.
- Stall (`adv`=0): every stage holds; `out_data` and `out_tag` are stable while `out_valid`=1 and `out_ready`=0.
- `flush`: all valid bits clear on the next edge, including an operation accepted in the same cycle. `flush` has priority over `in_valid`. Data registers may keep stale values.
- `rst` asserted mid-operation: in-flight results are discarded and never emitted.
- Throughput: one operation per cycle while `out_ready`=1.

## Configuration
- `SPU_ROT_QUAD_EN` defined:
  - ROTQBY rotates the 128-bit `ra` left by `rb[124:127]` bytes.
  - SHLQBY shifts left by `rb[123:127]` bytes with zero fill; count >= 16 gives 0.
- Not defined: opcodes 100/101 behave as reserved (pass `ra`), and the byte-rotate logic is absent.

## Test plan
- Word ROT: `ra` lane0 = 0x80000001, `rb` lane0 = 0x00000021 (c=1) -> lane0 0x00000003 after `PIPE_STAGES` cycles; other lanes match a reference model.
- Halfword SHL and ROTMA:
  - SHL with lane 0x1234, count 16 -> 0x0000; count 4 -> 0x2340.
  - Word ROTMA with 0x80000000, count 0xFFFFFFFC (c=4) -> 0xF8000000.
- Back-to-back stream of 8 operations with `out_ready`=1 -> 8 consecutive `out_valid` cycles, tags in order.
- Hold `out_ready`=0 for 3 cycles while `out_valid`=1 -> `out_data` and `out_tag` held, `in_ready`=0; releasing it drains in order with no loss or duplication.
- Assert `flush` with 2 operations in flight plus one being accepted -> no `out_valid` for any of them. An operation issued the next cycle emerges normally.
- With `SPU_ROT_QUAD_EN`: ROTQBY `ra`=0x00112233...EEFF, count 1 -> 0x112233...EEFF00. Without the macro: same stimulus returns `ra` unchanged.
